instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the decode-side immediate generator: packs opcode, register and immediate fields into RV32 instruction words.
- Also expands the LI and CALL pseudo-ops into one or two words.
- Sits between the boot/debug loader and instruction memory, so host-side tools can stream symbolic ops into the core.
- Valid/ready on both sides; full throughput for single-word ops.

Parameters:
CHECK_RANGE, 1, 1 = reject out-of-range or misaligned immediates; 0 = truncate silently.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_kind  in  3  KIND_R/I/S/B/U/J/LI/CALL (0..7)
in_opcode  in  7  opcode for R/I/S/B/U/J; ignored for LI/CALL
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (KIND_R only)
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  32  immediate or offset, two's complement
out_valid  out  1  out_instr valid
out_ready  in  1  consumer accepts word
out_instr  out  32  encoded instruction word
out_last  out  1  final word of the current request
err  out  1  one-cycle pulse: request rejected by range check

Behaviour:
- Reset: state EMPTY; out_valid=0, out_instr=0, out_last=0, err=0; in_ready=1 from the first cycle after reset. Reset mid-sequence drops any pending second word.
- Field placement is the exact inverse of decode:
  - I: imm[11:0] to [31:20].
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
  - U: imm[31:12] to [31:12].
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
  - R: funct7 to [31:25].
- Range check (CHECK_RANGE=1):
  - I/S: imm must be sign-extension of imm[11:0].
  - B: imm must fit signed 13 bits and imm[0]=0.
  - J: imm must fit signed 21 bits and imm[0]=0.
  - U: imm[11:0]=0.
  - R, LI and CALL are never rejected.
  - On violation the request is consumed, nothing is emitted, err=1 for exactly one cycle, state unchanged.
- hi/lo split for LI/CALL: lo = imm[11:0], read as signed; hi = (imm + 0x800)[31:12], with 32-bit wrap.
- LI:
  - If imm fits signed 12 bits: one word, ADDI rd,x0,lo.
  - Else if lo==0: one word, LUI rd,hi.
  - Else: two words, LUI rd,hi then ADDI rd,rd,lo.
- CALL: always two words, AUIPC rd,hi then JALR rd,rd,lo (funct3=0).
- States:
  - EMPTY: no word held.
  - FIRST: first word of two held; second word stored internally.
  - LAST: final word held, out_last=1.
- Transitions:
  - EMPTY, accepted valid request: to FIRST if two words, else LAST. Rejected request stays in EMPTY.
  - FIRST with out_ready: load second word, go to LAST.
  - LAST with out_ready and no new accept: go to EMPTY.
  - LAST with out_ready and simultaneous accept: load the new request directly, no bubble.
- in_ready = (state==EMPTY) || (state==LAST && out_ready). It is 0 in FIRST.
- Latency: a request accepted in cycle N has its first word valid in N+1.
- While out_valid && !out_ready, out_instr and out_last must stay stable.
- err may pulse while state==LAST on a back-to-back reject; the held word is unaffected.

Decomposition:
- Shared package: kind enum; opcode localparams (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, CALCI, CALC, FLOAD, FSTORE, F, FBRANCH), also imported by immgen and the decoder; small helper functions for field packing per format.
- One sub-module, instr_pack: purely combinational format/field packer plus range checker. The parent keeps the FSM, output register and second-word register.

Test Plan:
- LI rd=5, imm=0x12345678 -> 0x123452B7 (out_last=0), then 0x67828293 (out_last=1).
- LI rd=1, imm=0x00000800 (carry into hi) -> 0x000010B7, then 0x80008093.
- LI rd=2, imm=0xFFFFFFFF -> single 0xFFF00113 with out_last=1. LI rd=3, imm=0x00010000 -> single 0x000101B7.
- KIND_B, opcode 0x63, funct3=0, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. The same request with imm=3 -> err pulse, no out_valid.
- Backpressure: out_ready=0 for 5 cycles during an LI two-word sequence -> word held stable and in_ready=0 in FIRST. Back-to-back single-word ops with out_ready=1 -> one word per cycle.
- rst asserted while in FIRST -> next cycle out_valid=0, in_ready=1, second word never emitted.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: request kinds, FSM states, RV32 opcodes and per-format field packers
package instr_encoder_pkg;
  typedef enum logic [2:0] {
    KIND_R, KIND_I, KIND_S, KIND_B, KIND_U, KIND_J, KIND_LI, KIND_CALL
  } kind_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_FIRST, ST_LAST} state_e;
  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_AUIPC   = 7'h17;
  localparam logic [6:0] OP_JAL     = 7'h6f;
  localparam logic [6:0] OP_JALR    = 7'h67;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_CALCI   = 7'h13;
  localparam logic [6:0] OP_CALC    = 7'h33;
  localparam logic [6:0] OP_FLOAD   = 7'h07;
  localparam logic [6:0] OP_FSTORE  = 7'h27;
  localparam logic [6:0] OP_F       = 7'h53;
  localparam logic [6:0] OP_FBRANCH = 7'h5b;
  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:1] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [31:12] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [6:0] op, input logic [4:0] rd, input logic [20:1] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request side (in_*) and instruction-word side (out_*, err) of the encoder; master = host, slave = encoder
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;
  modport master (
    output in_valid, in_kind, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_last, err
  );
  modport slave (
    input  in_valid, in_kind, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_last, err
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational field packer (word0/word1, two-word flag) and immediate range checker (bad)
module instr_pack import instr_encoder_pkg::*; #(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic [2:0]  kind,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        two,
  output logic        bad
);
  kind_e       k;
  logic [19:0] hi;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  assign k      = kind_e'(kind);
  assign hi     = imm[31:12] + {19'd0, imm[11]};
  assign fits12 = imm == {{20{imm[11]}}, imm[11:0]};
  assign fits13 = imm == {{19{imm[12]}}, imm[12:0]};
  assign fits21 = imm == {{11{imm[20]}}, imm[20:0]};
  always_comb begin
    word1 = enc_i(k == KIND_CALL ? OP_JALR : OP_CALCI, 3'd0, rd, rd, imm[11:0]);
    two   = k == KIND_CALL || (k == KIND_LI && !fits12 && imm[11:0] != 12'd0);
    case (k)
      KIND_R:  word0 = enc_r(opcode, funct3, funct7, rd, rs1, rs2);
      KIND_I:  word0 = enc_i(opcode, funct3, rd, rs1, imm[11:0]);
      KIND_S:  word0 = enc_s(opcode, funct3, rs1, rs2, imm[11:0]);
      KIND_B:  word0 = enc_b(opcode, funct3, rs1, rs2, imm[12:1]);
      KIND_U:  word0 = enc_u(opcode, rd, imm[31:12]);
      KIND_J:  word0 = enc_j(opcode, rd, imm[20:1]);
      KIND_LI: word0 = fits12 ? enc_i(OP_CALCI, 3'd0, rd, 5'd0, imm[11:0]) : enc_u(OP_LUI, rd, hi);
      default: word0 = enc_u(OP_AUIPC, rd, hi);
    endcase
    bad = CHECK_RANGE && ((k == KIND_I || k == KIND_S) ? !fits12 :
                          k == KIND_B ? (!fits13 || imm[0]) :
                          k == KIND_J ? (!fits21 || imm[0]) :
                          k == KIND_U ? imm[11:0] != 12'd0 : 1'b0);
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams symbolic ops (bus.in_*) into RV32 words (bus.out_*), expanding LI/CALL; bus.err flags rejected immediates
module instr_encoder import instr_encoder_pkg::*; #(
  parameter bit CHECK_RANGE = 1'b1
) (
  input logic           clk,
  input logic           rst,
  instr_encoder_if.slave bus
);
  state_e      state_q, state_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] second_q, second_d;
  logic        out_last_q, out_last_d;
  logic        err_q, err_d;
  logic [31:0] word0, word1;
  logic        two, bad, accept, load, adv, drain;
  instr_pack #(.CHECK_RANGE(CHECK_RANGE)) u_pack (
    .kind(bus.in_kind), .opcode(bus.in_opcode), .funct3(bus.in_funct3), .funct7(bus.in_funct7),
    .rd(bus.in_rd), .rs1(bus.in_rs1), .rs2(bus.in_rs2), .imm(bus.in_imm),
    .word0(word0), .word1(word1), .two(two), .bad(bad)
  );
  assign bus.in_ready  = state_q == ST_EMPTY || (state_q == ST_LAST && bus.out_ready);
  assign bus.out_valid = state_q != ST_EMPTY;
  assign bus.out_instr = out_instr_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;
  assign accept = bus.in_valid && bus.in_ready;
  assign load   = accept && !bad;
  assign adv    = bus.out_ready && state_q == ST_FIRST;
  assign drain  = bus.out_ready && state_q == ST_LAST;
  always_comb begin
    state_d     = load ? (two ? ST_FIRST : ST_LAST) : adv ? ST_LAST : drain ? ST_EMPTY : state_q;
    out_instr_d = load ? word0 : adv ? second_q : state_d == ST_EMPTY ? 32'd0 : out_instr_q;
    out_last_d  = load ? !two : adv ? 1'b1 : state_d != ST_EMPTY && out_last_q;
    second_d    = load ? word1 : second_q;
    err_d       = accept && bad;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_instr_q <= '0;
      second_q    <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_instr_q <= out_instr_d;
      second_q    <= second_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end
endmodule
